// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: redirect, instruction memory read port, decode stream.
// master = fetch_queue side, slave = memory/decode/branch side.
interface fetch_queue_if #(
    parameter int SIZE = 32
);
    logic            redirect;
    logic [SIZE-1:0] redirect_addr;
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_data;
    logic [SIZE-1:0] instr_pc;

    modport master (
        input  redirect, redirect_addr,
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect, redirect_addr,
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word reads and buffers {pc, instr} for decode.
// Ports: clk, rst (async active-low), bus (fetch_queue_if.master).
module fetch_queue #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state;
    logic [SIZE-1:0] faddr;
    logic [SIZE-1:0] daddr;
    logic [31:0]     q_data [DEPTH];
    logic [SIZE-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            pop;
    logic            push;
    logic            has_room;

    assign pop  = (count != '0) && bus.instr_ready;
    assign push = (state == REQ) && bus.imem_ack && !bus.redirect;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    assign has_room = count_next < FULL;

    // daddr keeps the abandoned address visible until the memory acks it.
    assign bus.imem_req    = (state != IDLE);
    assign bus.imem_addr   = (state == DROP) ? daddr : faddr;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = q_data[rd_ptr];
    assign bus.instr_pc    = q_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            faddr  <= '0;
            daddr  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (bus.redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            faddr  <= bus.redirect_addr & ~SIZE'(3);
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (!bus.imem_ack) begin
                        state <= DROP;
                        daddr <= faddr;
                    end
                end
                DROP: state <= bus.imem_ack ? REQ : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            count <= count_next;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push) begin
                q_data[wr_ptr] <= bus.imem_data;
                q_pc[wr_ptr]   <= faddr;
                wr_ptr         <= wr_ptr + 1'b1;
                faddr          <= faddr + SIZE'(4);
            end
            unique case (state)
                IDLE: state <= has_room ? REQ : IDLE;
                REQ: begin
                    if (bus.imem_ack)
                        state <= has_room ? REQ : IDLE;
                end
                DROP: begin
                    if (bus.imem_ack)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable memory model.
// Ports driven through fetch_queue_if; expected values hand-computed.
module tb_fetch_queue;
    logic clk;
    logic rst;
    int   lat;
    int   wait_cnt;
    int   checks;
    int   errors;

    fetch_queue_if #(.SIZE(32)) bus ();

    fetch_queue #(.SIZE(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_ack  = bus.imem_req && (wait_cnt >= lat);
    assign bus.imem_data = word(bus.imem_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= 0;
        else if (bus.imem_req && !bus.imem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready = 1'b0;
        lat = 0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready = 1'b1;
        lat = 0;
        repeat (2) tick();
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b want 0", bus.imem_req);
        end
        checks++;
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_addr got %h want 0", bus.imem_addr);
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", bus.instr_valid);
        end
        checks++;
        if (bus.instr_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_data got %h want 0", bus.instr_data);
        end
        checks++;
        if (bus.instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_pc got %h want 0", bus.instr_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        bus.instr_ready = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL stream_req1 got %b/%h want 1/0",
                     bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_valid1 got %b want 0", bus.instr_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = 32'(i * 4);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp) begin
                errors++;
                $display("FAIL stream_pc%0d got %b/%h want 1/%h",
                         i, bus.instr_valid, bus.instr_pc, exp);
            end
            checks++;
            if (bus.instr_data !== word(exp)) begin
                errors++;
                $display("FAIL stream_data%0d got %h want %h",
                         i, bus.instr_data, word(exp));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        repeat (5) tick();
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_req got %b want 0", bus.imem_req);
        end
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_head got %b/%h want 1/0",
                     bus.instr_valid, bus.instr_pc);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got %b want 0", bus.imem_req);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL full_refill got %b/%h want 1/10",
                     bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (bus.instr_pc !== 32'h4) begin
            errors++;
            $display("FAIL full_pop_pc got %h want 4", bus.instr_pc);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_pc !== 32'h4) begin
            errors++;
            $display("FAIL full_single got %b/%h want 0/4",
                     bus.imem_req, bus.instr_pc);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_idle got %b want 0", bus.imem_req);
        end
    endtask

    task automatic test_wait();
        do_reset();
        lat = 3;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 ||
                bus.instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold%0d got %b/%h/%b want 1/0/0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid);
            end
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL wait_first got %b/%h want 1/0",
                     bus.instr_valid, bus.instr_pc);
        end
        checks++;
        if (bus.imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL wait_next_addr got %h want 4", bus.imem_addr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) tick();
        lat = 2;
        bus.redirect = 1'b1;
        bus.redirect_addr = 32'h0000_1003;
        tick();
        bus.redirect = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush got %b want 0", bus.instr_valid);
        end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL redir_drop_addr got %b/%h want 1/8",
                     bus.imem_req, bus.imem_addr);
        end
        tick();
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_discard got %b want 0", bus.instr_valid);
        end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL redir_new_addr got %b/%h want 1/1000",
                     bus.imem_req, bus.imem_addr);
        end
        lat = 0;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h1000) begin
            errors++;
            $display("FAIL redir_pc got %b/%h want 1/1000",
                     bus.instr_valid, bus.instr_pc);
        end
        checks++;
        if (bus.instr_data !== word(32'h1000)) begin
            errors++;
            $display("FAIL redir_data got %h want %h",
                     bus.instr_data, word(32'h1000));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFF8;
        exp[1] = 32'hFFFF_FFFC;
        exp[2] = 32'h0000_0000;
        do_reset();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_start got %b/%h want 0/fffffff8",
                     bus.instr_valid, bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp[i]) begin
                errors++;
                $display("FAIL wrap_pc%0d got %b/%h want 1/%h",
                         i, bus.instr_valid, bus.instr_pc, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) tick();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 ||
            bus.imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL areset_pre got %b/%h/%h want 1/0/c",
                     bus.instr_valid, bus.instr_pc, bus.imem_addr);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL areset_now got %b/%b want 0/0",
                     bus.instr_valid, bus.imem_req);
        end
        checks++;
        if (bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_regs got %h/%h want 0/0",
                     bus.instr_pc, bus.imem_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_restart got %b/%h want 1/0",
                     bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL areset_first got %b/%h want 1/0",
                     bus.instr_valid, bus.instr_pc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_full();
        test_wait();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
